// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants and helpers for the NTT butterfly datapath
package ntt_pkg;

    localparam int          W_DEF = 28;
    localparam int unsigned Q_DEF = 32'd268369921;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

    // floor(2^(2w)/q); valid for w <= 31
    function automatic logic [63:0] barrett_mu(input int w, input logic [63:0] q);
        return (64'd1 << (2 * w)) / q;
    endfunction

    localparam logic [63:0] MU = barrett_mu(W_DEF, 64'(Q_DEF));

endpackage

// File: rtl/ntt_butterfly_pipe_mult.sv
// rtl/ntt_butterfly_pipe_mult.sv - pipelined Barrett modular multiplier, p = a*b mod Q
//
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   a, b     : operands, both < Q, one pair accepted every cycle
//   p        : (a*b) mod Q, MULT_LAT cycles after a/b are sampled
module mod_mult_pipe
    import ntt_pkg::*;
#(
    parameter int          W        = W_DEF,
    parameter int unsigned Q        = Q_DEF,
    parameter int          MULT_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    localparam logic [W:0]   MU_W = (W+1)'(barrett_mu(W, 64'(Q)));
    localparam logic [W+1:0] Q_X  = (W+2)'(Q);
    localparam int           TAIL = MULT_LAT - 3;

    logic [2*W-1:0] prod_s1;
    logic [W+1:0]   prod_s2;
    logic [2*W+1:0] q2;
    logic [W:0]     q3_next;
    logic [W:0]     q3_s2;
    logic [W+1:0]   r0;
    logic [W+1:0]   r1;
    logic [W+1:0]   r2;
    logic [W-1:0]   r_pipe [TAIL+1];

    // Barrett estimate: q3 = floor(floor(x / 2^(W-1)) * MU / 2^(W+1)).
    // The remainder x - q3*Q lies in [0, 3Q) and is below 2^(W+2), so only the
    // low W+2 bits of x and q3*Q are needed, followed by two conditional subtracts.
    assign q2      = (2*W+2)'(prod_s1[2*W-1:W-1]) * (2*W+2)'(MU_W);
    assign q3_next = (W+1)'(q2 >> (W+1));
    assign r0      = prod_s2 - Q_X * {1'b0, q3_s2};
    assign r1      = (r0 >= Q_X) ? r0 - Q_X : r0;
    assign r2      = (r1 >= Q_X) ? r1 - Q_X : r1;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_s1 <= '0;
            prod_s2 <= '0;
            q3_s2   <= '0;
            for (int i = 0; i <= TAIL; i++) r_pipe[i] <= '0;
        end else begin
            prod_s1   <= (2*W)'(a) * (2*W)'(b);
            prod_s2   <= prod_s1[W+1:0];
            q3_s2     <= q3_next;
            r_pipe[0] <= W'(r2);
            for (int i = 1; i <= TAIL; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign p = r_pipe[TAIL];

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// rtl/ntt_butterfly_pipe.sv - pipelined radix-2 CT/GS NTT butterfly with runtime twiddle
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   in_valid, mode   : sample pair valid; 0 = Cooley-Tukey, 1 = Gentleman-Sande
//   x_in, y_in, w_in : operands and twiddle, all < Q
//   out_valid        : new result on x_out/y_out, exactly LAT cycles after in_valid
//   x_out, y_out     : results < Q; held between valid beats
module ntt_butterfly_pipe
    import ntt_pkg::*;
#(
    parameter int          W        = W_DEF,
    parameter int unsigned Q        = Q_DEF,
    parameter int          MULT_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         mode,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] w_in,
    output logic         out_valid,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out
);

    localparam int         LAT = MULT_LAT + 2;
    localparam logic [W:0] Q_E = (W+1)'(Q);
    localparam logic [W-1:0] Q_W = W'(Q);

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= Q_E) ? W'(s - Q_E) : W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? a - b + Q_W : a - b;
    endfunction

    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;
    logic [W-1:0]  s1_w;
    logic [W-1:0]  prod;
    logic [W-1:0]  a_dly [MULT_LAT];
    logic [W-1:0]  xd;
    logic [LAT-1:0]    vld_sr;
    logic [MULT_LAT:0] md_sr;
    logic          md_out;
    logic          load_out;

    // Both modes enter the shared multiplier at the same pipeline slot, so
    // consecutive samples of different modes never compete for it. Stage 1
    // holds (x, y, w) for CT and (x+y, x-y, w) for GS; the multiplier then
    // always sees (s1_b, s1_w) and s1_a rides alongside in a delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a <= '0;
            s1_b <= '0;
            s1_w <= '0;
        end else begin
            s1_a <= (mode == MODE_GS) ? mod_add(x_in, y_in) : x_in;
            s1_b <= (mode == MODE_GS) ? mod_sub(x_in, y_in) : y_in;
            s1_w <= w_in;
        end
    end

    mod_mult_pipe #(
        .W        (W),
        .Q        (Q),
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk (clk),
        .rst (rst),
        .a   (s1_b),
        .b   (s1_w),
        .p   (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) a_dly[i] <= '0;
            vld_sr <= '0;
            md_sr  <= '0;
        end else begin
            a_dly[0] <= s1_a;
            for (int i = 1; i < MULT_LAT; i++) a_dly[i] <= a_dly[i-1];
            vld_sr <= {vld_sr[LAT-2:0], in_valid};
            md_sr  <= {md_sr[MULT_LAT-1:0], mode};
        end
    end

    // Entry MULT_LAT of each shift register lines up with the multiplier output.
    assign xd       = a_dly[MULT_LAT-1];
    assign md_out   = md_sr[MULT_LAT];
    assign load_out = vld_sr[LAT-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            x_out <= '0;
            y_out <= '0;
        end else if (load_out) begin
            if (md_out == MODE_GS) begin
                x_out <= xd;
                y_out <= prod;
            end else begin
                x_out <= mod_add(xd, prod);
                y_out <= mod_sub(xd, prod);
            end
        end
    end

    assign out_valid = vld_sr[LAT-1];

    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            assert (x_in < Q_W && y_in < Q_W && w_in < Q_W);
        end
    end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// tb/tb_ntt_butterfly_pipe.sv - self-checking bench for ntt_butterfly_pipe
module tb_ntt_butterfly_pipe;

    localparam int              W        = 28;
    localparam int              MULT_LAT = 4;
    localparam int              LAT      = MULT_LAT + 2;
    localparam longint unsigned Q        = 64'd268369921;
    localparam int unsigned     QI       = 32'd268369921;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] w_in = '0;
    logic         out_valid;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;

    int checks = 0;
    int failures = 0;

    logic         sv_v [64];
    logic         sv_m [64];
    logic [W-1:0] sv_x [64];
    logic [W-1:0] sv_y [64];
    logic [W-1:0] sv_w [64];
    logic         ob_v [64];
    logic [W-1:0] ob_x [64];
    logic [W-1:0] ob_y [64];

    ntt_butterfly_pipe #(
        .W        (W),
        .Q        (QI),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .x_out     (x_out),
        .y_out     (y_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_x(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] w);
        longint unsigned t;
        if (m) t = (64'(x) + 64'(y)) % Q;
        else   t = (64'(x) + (64'(w) * 64'(y)) % Q) % Q;
        return W'(t);
    endfunction

    function automatic logic [W-1:0] ref_y(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] w);
        longint unsigned t;
        if (m) t = (((64'(x) + Q - 64'(y)) % Q) * 64'(w)) % Q;
        else   t = (64'(x) + Q - (64'(w) * 64'(y)) % Q) % Q;
        return W'(t);
    endfunction

    // One beat, then watch LAT+3 cycles; lat is the edge offset of the first out_valid.
    task automatic run_single(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] w, output int lat, output int pulses,
                              output logic [W-1:0] xo, output logic [W-1:0] yo);
        mode = m; x_in = x; y_in = y; w_in = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1; pulses = 0; xo = '0; yo = '0;
        for (int j = 0; j < LAT + 3; j++) begin
            if (out_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = j + 1; xo = x_out; yo = y_out;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_stream(input int n);
        for (int c = 0; c < n + LAT + 1; c++) begin
            if (c < n) begin
                in_valid = sv_v[c]; mode = sv_m[c];
                x_in = sv_x[c]; y_in = sv_y[c]; w_in = sv_w[c];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            ob_v[c] = out_valid; ob_x[c] = x_out; ob_y[c] = y_out;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (x_out !== '0) begin failures++; $display("FAIL reset_x: got %0d expected 0", x_out); end
        checks++; if (y_out !== '0) begin failures++; $display("FAIL reset_y: got %0d expected 0", y_out); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single(input string name, input logic m, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] w,
                               input logic [W-1:0] ex, input logic [W-1:0] ey);
        int lat, pulses;
        logic [W-1:0] xo, yo;
        run_single(m, x, y, w, lat, pulses, xo, yo);
        checks++; if (lat != LAT) begin failures++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL %s_pulses: got %0d expected 1", name, pulses); end
        checks++; if (xo !== ex) begin failures++; $display("FAIL %s_x: got %0d expected %0d", name, xo, ex); end
        checks++; if (yo !== ey) begin failures++; $display("FAIL %s_y: got %0d expected %0d", name, yo, ey); end
    endtask

    task automatic test_back_to_back();
        int idx;
        logic [W-1:0] ex, ey;
        for (int i = 0; i < 16; i++) begin
            sv_v[i] = 1'b1; sv_m[i] = i[0];
            sv_x[i] = W'($urandom_range(QI - 1, 0));
            sv_y[i] = W'($urandom_range(QI - 1, 0));
            sv_w[i] = W'($urandom_range(QI - 1, 0));
        end
        sv_x[3] = W'(QI - 1); sv_y[3] = W'(QI - 1); sv_w[3] = W'(QI - 1);
        run_stream(16);
        for (int c = 0; c < 16 + LAT + 1; c++) begin
            idx = c - (LAT - 1);
            if (idx >= 0 && idx < 16) begin
                ex = ref_x(sv_m[idx], sv_x[idx], sv_y[idx], sv_w[idx]);
                ey = ref_y(sv_m[idx], sv_x[idx], sv_y[idx], sv_w[idx]);
                checks++; if (ob_v[c] !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c, ob_v[c]); end
                checks++; if (ob_x[c] !== ex || ob_y[c] !== ey) begin
                    failures++;
                    $display("FAIL b2b_data[%0d]: got %0d/%0d expected %0d/%0d", idx, ob_x[c], ob_y[c], ex, ey);
                end
            end else begin
                checks++; if (ob_v[c] !== 1'b0) begin failures++; $display("FAIL b2b_idle[%0d]: got %b expected 0", c, ob_v[c]); end
            end
        end
    endtask

    task automatic test_bubbles();
        int idx;
        logic ev, seen;
        logic [W-1:0] ex, ey, last_x, last_y;
        for (int i = 0; i < 18; i++) begin
            sv_v[i] = !(i == 8 || i == 9); sv_m[i] = i[1];
            sv_x[i] = W'($urandom_range(QI - 1, 0));
            sv_y[i] = W'($urandom_range(QI - 1, 0));
            sv_w[i] = W'($urandom_range(QI - 1, 0));
        end
        run_stream(18);
        seen = 1'b0; last_x = '0; last_y = '0;
        for (int c = 0; c < 18 + LAT + 1; c++) begin
            idx = c - (LAT - 1);
            ev = 1'b0;
            if (idx >= 0 && idx < 18) ev = sv_v[idx];
            checks++; if (ob_v[c] !== ev) begin failures++; $display("FAIL gap_valid[%0d]: got %b expected %b", c, ob_v[c], ev); end
            if (ev) begin
                ex = ref_x(sv_m[idx], sv_x[idx], sv_y[idx], sv_w[idx]);
                ey = ref_y(sv_m[idx], sv_x[idx], sv_y[idx], sv_w[idx]);
                checks++; if (ob_x[c] !== ex || ob_y[c] !== ey) begin
                    failures++;
                    $display("FAIL gap_data[%0d]: got %0d/%0d expected %0d/%0d", idx, ob_x[c], ob_y[c], ex, ey);
                end
                seen = 1'b1; last_x = ex; last_y = ey;
            end else if (seen) begin
                checks++; if (ob_x[c] !== last_x || ob_y[c] !== last_y) begin
                    failures++;
                    $display("FAIL gap_hold[%0d]: got %0d/%0d expected %0d/%0d", c, ob_x[c], ob_y[c], last_x, last_y);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, pulses;
        logic [W-1:0] xo, yo;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; mode = i[0];
            x_in = W'(100 + i); y_in = W'(7); w_in = W'(9);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < LAT + 3; j++) begin
            checks++; if (out_valid !== 1'b0 || x_out !== '0 || y_out !== '0) begin
                failures++;
                $display("FAIL rstmid_quiet[%0d]: got v=%b x=%0d y=%0d expected v=0 x=0 y=0", j, out_valid, x_out, y_out);
            end
            @(posedge clk); #1;
        end
        run_single(1'b1, W'(10), W'(4), W'(3), lat, pulses, xo, yo);
        checks++; if (lat != LAT) begin failures++; $display("FAIL rstmid_latency: got %0d expected %0d", lat, LAT); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL rstmid_pulses: got %0d expected 1", pulses); end
        checks++; if (xo !== W'(14) || yo !== W'(18)) begin
            failures++;
            $display("FAIL rstmid_data: got %0d/%0d expected 14/18", xo, yo);
        end
    endtask

    initial begin
        test_reset();
        test_single("ct_basic", 1'b0, W'(5), W'(3), W'(2), W'(11), W'(268369920));
        test_single("gs_basic", 1'b1, W'(5), W'(3), W'(2), W'(8), W'(4));
        test_single("ct_wrap_hi", 1'b0, W'(268369920), W'(1), W'(1), W'(0), W'(268369919));
        test_single("ct_wrap_sq", 1'b0, W'(0), W'(268369920), W'(268369920), W'(1), W'(268369920));
        test_single("ct_zero_w", 1'b0, W'(123456), W'(999), W'(0), W'(123456), W'(123456));
        test_back_to_back();
        test_bubbles();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
